// File: rtl/result_pkg.sv
// ----------------------------------------------------------------------------
// result_pkg
// Shared types and constants for the result-memory read sequencer.
//   rd_state_e    : read sequencer FSM states
//   RD_FIFO_DEPTH : number of output buffer entries, which is also the number
//                   of read credits
// ----------------------------------------------------------------------------
package result_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

    localparam int RD_FIFO_DEPTH = 3;

endpackage

// File: rtl/result_rd_fifo.sv
// ----------------------------------------------------------------------------
// result_rd_fifo
// Small synchronous FIFO that buffers words returned by the result memory
// until the downstream consumer accepts them.
//   clk_i        in   clock
//   rst_ni       in   asynchronous active-low reset (empties the FIFO)
//   push_i       in   write push_data_i at the next edge
//   push_data_i  in   word to write
//   pop_i        in   drop the head word at the next edge
//   empty_o      out  no words stored
//   occupancy_o  out  number of words stored
//   head_o       out  oldest stored word (undefined content when empty)
// Push on a full FIFO is not guarded: the caller's credit scheme prevents it.
// ----------------------------------------------------------------------------
module result_rd_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 3,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic [CW-1:0]    occupancy_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_i) - CW'(pop_i);
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                entry_q[gi] <= '0;
            end else if (push_i && (wr_ptr_q == PW'(gi))) begin
                entry_q[gi] <= push_data_i;
            end
        end
    end

    assign empty_o     = (count_q == '0);
    assign occupancy_o = count_q;
    assign head_o      = entry_q[rd_ptr_q];

endmodule

// File: rtl/result_reader.sv
// ----------------------------------------------------------------------------
// result_reader
// Reads a contiguous, wrap-around range of words from a synchronous-read
// result memory and streams them out over valid/ready, tolerating any amount
// of output backpressure. Completion is signalled by a one-cycle done pulse.
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   start_i                    start a transfer (ignored while busy_o)
//   base_addr_i, count_i       first address and word count (clamped to depth)
//   busy_o, done_o             transfer in progress / completion pulse
//   mem_re_o, mem_addr_o       memory read port request
//   mem_rdata_i                memory data, valid the cycle after mem_re_o
//   out_valid_o, out_ready_i   output handshake
//   out_data_o, out_last_o     output word and end-of-transfer marker
// ----------------------------------------------------------------------------
module result_reader
    import result_pkg::*;
#(
    parameter  int MEM_WIDTH = 32,
    parameter  int MEM_DEPTH = 8,
    localparam int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [AW-1:0]        base_addr_i,
    input  logic [AW:0]          count_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 mem_re_o,
    output logic [AW-1:0]        mem_addr_o,
    input  logic [MEM_WIDTH-1:0] mem_rdata_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [MEM_WIDTH-1:0] out_data_o,
    output logic                 out_last_o
);

    localparam int CNTW = AW + 1;
    localparam int OW   = $clog2(RD_FIFO_DEPTH + 1);

    rd_state_e      state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW:0]    remaining_q, remaining_d;    // reads still to issue
    logic [AW:0]    beats_left_q, beats_left_d;  // handshakes still to see
    logic           inflight_q, inflight_d;

    logic [AW:0]          count_clamped;
    logic                 fifo_empty;
    logic [OW-1:0]        fifo_occ;
    logic [MEM_WIDTH-1:0] fifo_head;
    logic                 credit_ok;
    logic                 handshake;

    assign count_clamped = (count_i > CNTW'(MEM_DEPTH)) ? CNTW'(MEM_DEPTH) : count_i;

    // A read is only issued when a FIFO slot is guaranteed for its data, so
    // the returning word can always be written without checking for space.
    assign credit_ok = ((OW + 1)'(fifo_occ) + (OW + 1)'(inflight_q)) < (OW + 1)'(RD_FIFO_DEPTH);
    assign mem_re_o  = (state_q == READ) && (remaining_q != '0) && credit_ok;

    assign out_valid_o = !fifo_empty;
    assign handshake   = out_valid_o && out_ready_i;
    assign out_data_o  = out_valid_o ? fifo_head : '0;
    assign out_last_o  = out_valid_o && (beats_left_q == CNTW'(1));

    assign mem_addr_o = addr_q;
    assign busy_o     = (state_q == READ) || (state_q == DRAIN);
    assign done_o     = (state_q == DONE);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        beats_left_d = beats_left_q;
        inflight_d   = mem_re_o;

        if (mem_re_o) begin
            addr_d      = addr_q + 1'b1;   // natural AW-bit wrap
            remaining_d = remaining_q - 1'b1;
        end
        if (handshake) begin
            beats_left_d = beats_left_q - 1'b1;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                // DONE has busy_o low, so a new start is accepted there too.
                if (start_i) begin
                    addr_d       = base_addr_i;
                    remaining_d  = count_clamped;
                    beats_left_d = count_clamped;
                    state_d      = (count_clamped == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (mem_re_o && (remaining_q == CNTW'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake && (beats_left_q == CNTW'(1))) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            beats_left_q <= '0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            beats_left_q <= beats_left_d;
            inflight_q   <= inflight_d;
        end
    end

    result_rd_fifo #(
        .WIDTH (MEM_WIDTH),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (inflight_q),
        .push_data_i (mem_rdata_i),
        .pop_i       (handshake),
        .empty_o     (fifo_empty),
        .occupancy_o (fifo_occ),
        .head_o      (fifo_head)
    );

endmodule
